// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Byte-output bundle from the UART receiver to the status-decode stage.
`timescale 1ns/1ps
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_receive;
  logic                      data_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (
    output data_receive,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input data_receive,
    input data_valid,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for a single asynchronous input; flops preset high.
`timescale 1ns/1ps
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_r;

  // shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {SYNC_STAGES{1'b1}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART byte receiver: mid-bit sampling, glitch rejection, framing-error and break handling.
`timescale 1ns/1ps
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_frame_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_t                 state_r, state_nx;
  logic [CNT_W-1:0]          cnt_r, cnt_nx;
  logic [IDX_W-1:0]          idx_r, idx_nx;
  logic [UART_DATA_BITS-1:0] shift_r, shift_nx;
  logic [UART_DATA_BITS-1:0] data_r, data_nx;
  logic                      valid_r, valid_nx;
  logic                      ferr_r, ferr_nx;
  logic                      busy_r, busy_nx;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      idx_r   <= idx_nx;
      shift_r <= shift_nx;
      data_r  <= data_nx;
      valid_r <= valid_nx;
      ferr_r  <= ferr_nx;
      busy_r  <= busy_nx;
    end
  end

  // next-state and output decode
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    data_nx  = data_r;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        // a start bit that is high again at its centre was only a glitch
        if (cnt_r == HALF_M1) begin
          if (rx_s) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            cnt_nx   = '0;
            idx_nx   = '0;
          end
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift_r[UART_DATA_BITS-1:1]};
          if (idx_r == LAST_IDX) begin
            state_nx = STOP;
          end else begin
            idx_nx = idx_r + IDX_W'(1);
          end
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shift_r;
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = BREAK;
          end
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = BREAK;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy_nx = (state_nx != IDLE);

  assign bus.data_receive = data_r;
  assign bus.data_valid   = valid_r;
  assign bus.frame_err    = ferr_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized scoreboard bench for uart_rx_frame at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int    CPB     = 16;
  localparam real   CLK_NS  = 10.0;
  localparam real   BIT_NS  = CPB * CLK_NS;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rx;

  uart_rx_frame_if bus ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         busy_seen = 0;
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #(CLK_NS / 2.0) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial line driver; the model's expectation is pushed when the frame is issued.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input real bit_ns, input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.is_err = !stop_hi;
      e.data   = b;
      exp_q.push_back(e);
    end
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_hi;
    #(bit_ns);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3 * CPB) @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
  endtask

  // Monitor: pop the scoreboard whenever the DUT reports a byte or framing error.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.busy) busy_seen++;
      if (bus.data_valid || bus.frame_err) begin
        chk("valid_err_exclusive", {31'd0, bus.data_valid & bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_is_err", {31'd0, bus.frame_err}, {31'd0, e.is_err});
          if (!e.is_err) begin
            chk("data_receive", {24'd0, bus.data_receive}, {24'd0, e.data});
            last_good = e.data;
          end else begin
            chk("data_hold_on_err", {24'd0, bus.data_receive}, {24'd0, last_good});
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    real        skew_ns;
    rx    = 1'b1;
    rst_n = 1'b1;
    #3;
    do_reset();
    @(negedge clk);
    chk("reset_data", {24'd0, bus.data_receive}, 32'h00);
    chk("reset_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("reset_ferr", {31'd0, bus.frame_err}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);

    // single byte
    send_frame(8'h35, 1'b1, BIT_NS, 1'b1);
    wait_drain("drain_35", 20 * CPB);
    @(negedge clk);
    chk("busy_after_35", {31'd0, bus.busy}, 32'd0);

    // back-to-back frames, one stop bit
    send_frame(8'h01, 1'b1, BIT_NS, 1'b1);
    send_frame(8'h80, 1'b1, BIT_NS, 1'b1);
    wait_drain("drain_b2b", 30 * CPB);

    // short low glitch on an idle line
    busy_seen = 0;
    @(posedge clk);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_seen", {31'd0, busy_seen != 0}, 32'd1);
    chk("glitch_busy_low", {31'd0, bus.busy}, 32'd0);
    chk("glitch_data_hold", {24'd0, bus.data_receive}, {24'd0, last_good});

    // framing error followed by a held-low line, then recovery
    send_frame(8'hA5, 1'b0, BIT_NS, 1'b1);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    rx = 1'b1;
    wait_drain("drain_ferr", 20 * CPB);
    chk("ferr_data_hold", {24'd0, bus.data_receive}, 32'h80);
    send_frame(8'h5A, 1'b1, BIT_NS, 1'b1);
    wait_drain("drain_5A", 20 * CPB);

    // reset asserted during data bit 3 of an aborted frame
    fork
      send_frame(8'hFF, 1'b1, BIT_NS, 1'b0);
      begin
        #(BIT_NS * 4.5);
        rst_n = 1'b0;
        #(BIT_NS * 0.5);
        rst_n = 1'b1;
        last_good = 8'h00;
      end
    join
    @(negedge clk);
    chk("midreset_data", {24'd0, bus.data_receive}, 32'h00);
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h3C, 1'b1, BIT_NS, 1'b1);
    wait_drain("drain_3C", 20 * CPB);

    // random stream with per-byte +/-2% sender baud skew
    #($urandom_range(0, 9));
    for (int n = 0; n < 200; n++) begin
      b       = 8'($urandom_range(0, 255));
      skew_ns = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
      send_frame(b, 1'b1, skew_ns, 1'b1);
    end
    wait_drain("drain_random", 30 * CPB);
    chk("final_data_hold", {24'd0, bus.data_receive}, {24'd0, last_good});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Byte-level UART receiver. Deserializes the asynchronous serial line into 8-bit words and issues a one-cycle data_valid strobe with data_receive held stable.
- Sits directly upstream of the status-decode stage, which consumes data_valid/data_receive and splits each byte into feedback flags.
- Guarantees LSB-first ordering with no lost or shifted bit. It also rejects glitches and framing errors so that the downstream stage never sees a corrupt byte.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit (100 MHz / 9600 baud); must be >= 8.
- SYNC_STAGES, 2, flip-flops in the rx metastability synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- data_receive  out  8  last good byte, bit0 = first data bit received.
- data_valid  out  1  one-cycle pulse when data_receive is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE, bit counter=0, clock counter=0.
  - data_receive=8'h00, data_valid=0, frame_err=0, busy=0.
  - Synchronizer flops preset to 1 (line idle).
- rx_s is the synchronizer output. All decisions use rx_s only; raw rx never reaches FSM logic.
- Counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, using integer division.
- IDLE: when rx_s==0, go to START and clear the clock counter. Call the cycle in which rx_s is first seen low t0.
- START: at count HALF-1, sample rx_s.
  - rx_s==1: glitch, return to IDLE, no output.
  - rx_s==0: go to DATA, clear the counter and bit index.
  - The start-bit centre is therefore sampled at t0+HALF.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register position bit_idx (LSB first).
  - Data bit i is sampled at t0+HALF+(i+1)*CLKS_PER_BIT.
  - After bit 7, go to STOP.
  - The shift register is internal; data_receive is not touched during DATA.
- STOP: sample rx_s at t0+HALF+9*CLKS_PER_BIT.
  - rx_s==1: on the next edge, data_receive <= shift register and data_valid=1 for exactly one cycle. Go to IDLE.
  - rx_s==0: frame_err=1 for one cycle, data_receive unchanged, data_valid stays 0. Go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A line held low never generates repeated bytes or errors.
- Back-to-back frames: a new start bit arriving while the stop bit is still high is only detected after returning to IDLE. This gives at least HALF cycles of margin, so consecutive frames with one stop bit are received with no loss.
- data_valid and frame_err are never high in the same cycle.
- data_receive holds its value until the next good byte.
- Reset mid-frame: the partial byte is discarded, outputs return to reset values, and the next falling edge starts a fresh frame.
- Sampling uses a single mid-bit sample; no majority vote.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - UART_DATA_BITS=8.
  - DEFAULT_CLKS_PER_BIT=10416.
- Sub-module sync_ff (parameter SYNC_STAGES, reset value 1) for the rx synchronizer, reusable for other async inputs.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Reset, then send byte 8'h35 (start, 1,0,1,0,1,1,0,0, stop) -> exactly one data_valid pulse; data_receive=8'h35; frame_err=0; busy low afterwards.
- Send 8'h01 then 8'h80 back-to-back with one stop bit each -> two data_valid pulses, values 8'h01 then 8'h80 in order; no bit shift (checks the lost-bit-0 regression).
- Low glitch of 4 cycles on idle line -> busy pulses high, then returns to IDLE; no data_valid, no frame_err; data_receive unchanged.
- Frame 8'hA5 with stop bit driven low, line held low for 40 cycles, then high -> one frame_err pulse, no data_valid, data_receive keeps its previous value. Then send 8'h5A -> data_valid with 8'h5A.
- Assert rst_n low during data bit 3 of 8'hFF, release, then send 8'h3C -> no output from the aborted frame; single data_valid with 8'h3C.
- Random 200-byte stream with ±2% baud skew on the sender -> every byte received correctly; frame_err never asserted.
